// File: rtl/count_history_pkg.sv
// count_history_pkg: shared defaults, clog2 helper and parameter check macro
`define CH_PARAM_CHECK(W, D, M) \
  if ((D) < 2 || ((D) & ((D) - 1)) != 0) begin : g_bad_depth \
    $error("count_history: DEPTH must be a power of two >= 2"); \
  end \
  if ((W) < 1 || (W) > 32 || (M) > ((64'd1 << (W)) - 64'd1)) begin : g_bad_max \
    $error("count_history: WIDTH out of range or MAX_COUNT exceeds 2**WIDTH-1"); \
  end
package count_history_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/history_ram.sv
// history_ram: DEPTH x WIDTH storage, one write port, registered read-before-write port
module history_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/count_history.sv
// count_history: up/down counter with terminal pulse, load, and age-addressed history ring
module count_history
  import count_history_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter int              DEPTH     = DEF_DEPTH,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  localparam int             AW        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             freeze,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic [AW:0]      fill
);
  `CH_PARAM_CHECK(WIDTH, DEPTH, MAX_COUNT)
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);
  localparam logic [AW:0]      FULL = (AW + 1)'(DEPTH);
  logic [WIDTH-1:0] r_count, w_next, w_load, w_q;
  logic [AW-1:0]    r_wp, w_raddr;
  logic [AW:0]      r_fill;
  logic             r_tc, r_rd_valid, w_wrap, w_we;
  always_comb begin
    w_wrap  = up ? (r_count == MAXC) : (r_count == '0);
    w_next  = w_wrap ? (up ? '0 : MAXC) : (up ? r_count + WIDTH'(1) : r_count - WIDTH'(1));
    w_load  = (load_value > MAXC) ? MAXC : load_value;
    w_we    = rst_n & ~load & en & ~freeze;
    w_raddr = r_wp - AW'(1) - rd_addr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_wp       <= '0;
      r_fill     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= load ? w_load : en ? w_next : r_count;
      r_tc       <= ~load & en & w_wrap;
      r_rd_valid <= {1'b0, rd_addr} < r_fill;
      if (w_we) begin
        r_wp   <= r_wp + AW'(1);
        r_fill <= (r_fill == FULL) ? r_fill : r_fill + (AW + 1)'(1);
      end
    end
  end
  // history stores the count from before the edge that advanced it
  history_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wp),
    .i_wdata (r_count),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );
  assign rd_data  = r_rd_valid ? w_q : '0;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign tc_pulse = r_tc;
  assign fill     = r_fill;
endmodule

// File: tb/tb_count_history.sv
// tb_count_history: directed checks of counting, wrap, load, freeze, history readback and reset
module tb_count_history;
  logic       clk = 1'b0;
  logic       rst_n, en, up, load, freeze;
  logic [7:0] load_value;
  logic [3:0] rd_addr;
  logic [7:0] a_rd_data, a_count, b_rd_data, b_count;
  logic       a_rd_valid, a_tc, b_rd_valid, b_tc;
  logic [4:0] a_fill, b_fill;
  int         checks = 0;
  int         errors = 0;
  int         seq [4] = '{1, 0, 9, 8};
  int         tcs [4] = '{0, 0, 1, 0};
  always #5 clk = ~clk;
  count_history d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_value(load_value),
    .freeze(freeze), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .count(a_count), .tc_pulse(a_tc), .fill(a_fill)
  );
  count_history #(.MAX_COUNT(9)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_value(load_value),
    .freeze(freeze), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .count(b_count), .tc_pulse(b_tc), .fill(b_fill)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_value = '0; freeze = 1'b0; rd_addr = '0;
    step();
    step();
    chk("rst_count", a_count, 0);
    chk("rst_tc", a_tc, 0);
    chk("rst_fill", a_fill, 0);
    chk("rst_valid", a_rd_valid, 0);
    chk("rst_data", a_rd_data, 0);
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("up_count", a_count, i % 256);
      chk("up_tc", a_tc, (i == 256) ? 1 : 0);
      chk("up_fill", a_fill, (i < 16) ? i : 16);
    end
    rst_n = 1'b0; en = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b1;
    repeat (5) step();
    chk("h5_count", a_count, 5);
    chk("h5_fill", a_fill, 5);
    en = 1'b0; rd_addr = 4'd5;
    step();
    chk("h5_age5_valid", a_rd_valid, 0);
    chk("h5_age5_data", a_rd_data, 0);
    rd_addr = 4'd4;
    step();
    chk("h5_age4_valid", a_rd_valid, 1);
    chk("h5_age4_data", a_rd_data, 0);
    en = 1'b1;
    repeat (15) step();
    chk("h20_count", a_count, 20);
    chk("h20_fill", a_fill, 16);
    en = 1'b0; rd_addr = 4'd0;
    step();
    chk("h20_age0", a_rd_data, 19);
    chk("h20_age0_valid", a_rd_valid, 1);
    rd_addr = 4'd15;
    step();
    chk("h20_age15", a_rd_data, 4);
    load = 1'b1; en = 1'b1; load_value = 8'h40;
    step();
    chk("ld_count", a_count, 8'h40);
    chk("ld_tc", a_tc, 0);
    chk("ld_fill", a_fill, 16);
    load = 1'b0; en = 1'b0; rd_addr = 4'd0;
    step();
    chk("ld_age0", a_rd_data, 19);
    rd_addr = 4'd1;
    step();
    chk("ld_age1", a_rd_data, 18);
    freeze = 1'b1; en = 1'b1; rd_addr = 4'd0;
    repeat (10) step();
    chk("fz_count", a_count, 8'h4a);
    chk("fz_fill", a_fill, 16);
    en = 1'b0;
    step();
    chk("fz_age0", a_rd_data, 19);
    freeze = 1'b0; en = 1'b1;
    step();
    chk("rel_count", a_count, 8'h4b);
    chk("rel_same_edge_read", a_rd_data, 19);
    en = 1'b0;
    step();
    chk("rel_age0", a_rd_data, 8'h4a);
    rd_addr = 4'd1;
    step();
    chk("rel_age1", a_rd_data, 19);
    load = 1'b1; load_value = 8'd2; up = 1'b0;
    step();
    chk("dn_load", b_count, 2);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_count", b_count, seq[i]);
      chk("dn_tc", b_tc, tcs[i]);
    end
    en = 1'b0; load = 1'b1; load_value = 8'd200;
    step();
    chk("clamp_count", b_count, 9);
    chk("noclamp_count", a_count, 200);
    chk("clamp_tc", b_tc, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("m9_upwrap_count", b_count, 0);
    chk("m9_upwrap_tc", b_tc, 1);
    load = 1'b1; en = 1'b0; load_value = 8'hff;
    step();
    chk("pre_rst_count", a_count, 255);
    load = 1'b0; en = 1'b1; rst_n = 1'b0;
    step();
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_tc", a_tc, 0);
    chk("mid_rst_fill", a_fill, 0);
    chk("mid_rst_valid", a_rd_valid, 0);
    chk("mid_rst_b_count", b_count, 0);
    rst_n = 1'b1; en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      step();
      chk("post_rst_valid", a_rd_valid, 0);
      chk("post_rst_data", a_rd_data, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_history.md
Name: count_history

Overview:
- Parametrised successor to the free-running 8-bit counter with its 16-entry count memory used in simulation testbenches.
- Up/down counter with:
  - programmable terminal value
  - synchronous load
  - terminal-count pulse
  - ring-buffer history of past counts, read back by age
- Sits in the Verisocks test tops as the standard stimulus/observation block, so scripts can query count history over the socket.

Parameters:
- WIDTH, 8, counter and history data width (1..32).
- DEPTH, 16, history entries; power of two, >= 2.
- MAX_COUNT, 2**WIDTH-1, terminal value; count range is 0..MAX_COUNT.
- AW, $clog2(DEPTH), history address width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value for load.
- freeze  in  1  hold history (ring buffer, pointer, fill level).
- rd_addr  in  AW  read age; 0 = most recent entry.
- rd_data  out  WIDTH  registered history read data.
- rd_valid  out  1  rd_data corresponds to a written entry.
- count  out  WIDTH  current count.
- tc_pulse  out  1  one-cycle wrap indication.
- fill  out  AW+1  number of valid history entries, saturates at DEPTH.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - count=0, tc_pulse=0, rd_data=0, rd_valid=0, fill=0, write pointer=0.
  - History RAM is not reset; rd_valid guards stale entries.
  - Reset overrides all other inputs, including mid-load or mid-wrap.
- Priority per edge: reset > load > en.
- Load:
  - count <= min(load_value, MAX_COUNT).
  - tc_pulse <= 0.
  - No history write.
- en=1, load=0, counting:
  - up=1: count==MAX_COUNT -> count<=0 and tc_pulse<=1; otherwise count+1.
  - up=0: count==0 -> count<=MAX_COUNT and tc_pulse<=1; otherwise count-1.
  - If freeze=0, history[wp] <= pre-increment count, wp <= wp+1 (wraps modulo DEPTH), fill <= min(fill+1, DEPTH).
- en=0, load=0: count holds; tc_pulse <= 0; no history write.
- tc_pulse:
  - High exactly one cycle per wrap.
  - Back-to-back wraps (MAX_COUNT=0, en held) give tc_pulse high continuously.
- freeze=1:
  - Counter and tc_pulse behave normally.
  - RAM, wp and fill hold.
  - Releasing freeze resumes writing at the held wp.
- Read, latency 1 cycle:
  - rd_data <= history[(wp-1-rd_addr) mod DEPTH].
  - rd_valid <= (rd_addr < fill).
  - Both use wp/fill/RAM values from before the same edge's write, so a concurrent write is not visible until the next cycle.
  - When rd_valid=0, rd_data=0.
- Arithmetic: all count arithmetic is unsigned WIDTH-bit; no intermediate overflow reaches count.
- Elaboration error if DEPTH is not a power of two or MAX_COUNT > 2**WIDTH-1.

Decomposition:
- Package count_history_pkg:
  - clog2 helper function.
  - Parameter check macro.
  - Default constants (WIDTH=8, DEPTH=16).
- One sub-module, history_ram:
  - DEPTH x WIDTH storage.
  - Single write port, registered read port.
  - No reset on storage.
- Counter, pointer, fill and tc logic stay in count_history.

Test Plan:
- Reset and up-count, defaults: rst_n low 2 cycles, then en=1, up=1 for 256 cycles:
  - count 0->255->0.
  - tc_pulse high only on the edge where count goes 255->0.
  - fill saturates at 16.
- History readback: after 20 enabled up-counts from 0:
  - rd_addr=0 -> rd_data=19, rd_valid=1.
  - rd_addr=15 -> rd_data=4.
  - At fill=5 (after 5 counts), rd_addr=5 -> rd_valid=0, rd_data=0.
- Down-count with MAX_COUNT=9: load=1, load_value=2, then en=1, up=0:
  - Sequence 2,1,0,9,8.
  - tc_pulse on the 0->9 transition.
  - load_value=200 clamps count to 9.
- Load priority: load=1, en=1, load_value=0x40 in the same cycle:
  - count=0x40.
  - No history write: fill and wp unchanged.
  - tc_pulse=0.
- Freeze: freeze=1 for 10 enabled cycles:
  - count advances 10.
  - fill/wp unchanged.
  - rd_addr=0 returns the pre-freeze value.
  - After release, the next entry is written at the held wp.
- Mid-operation reset: rst_n=0 while count=255 with en=1:
  - Next cycle count=0, tc_pulse=0, fill=0, rd_valid=0 for all rd_addr.
